datapath: RTL and testbench
===========================

# datapath

Single-bus 32-bit CPU datapath: program counter, instruction register, memory address/data registers, a special-purpose HI register, sixteen general-purpose registers R0–R15 and a word-addressed internal memory, all connected through one bus multiplexer. An external control-step sequencer drives it one register transfer per clock. The first supported instruction path is fetch plus `mfhi Ra`, which copies HI into the register named by IR[26:23].

## Interface
Parameters:
- MEM_DEPTH, 512: internal memory words. The address is MAR[8:0].
- HI_INIT, 32'h0000_0000: HI register value after reset.

Ports:
- Clock  in  1  single system clock; every register updates on the rising edge.
- Clear  in  1  reset, asynchronous and active-high.
- CONTROL  in  5  reserved ALU/op control. Accepted but ignored in this block.
- IncPC  in  1  PC <= PC + 1 on the rising edge.
- Read  in  1  selects the memory read data as the MDR input.
- PC_Out, MDR_Out, HI_Out  in  1 each  bus drive enables.
- PC_In, MDR_In, MAR_In, IR_In  in  1 each  register load enables.
- G_RA  in  1  select the register decoded from IR[26:23].
- R_In  in  1  load enable for the selected general register.
- BusMux_Out  out  32  current bus value (combinational).

## Operation
- Bus mux is combinational. Priority: PC_Out > MDR_Out > HI_Out. With no enable asserted, the bus is 32'h0.
- PC:
  - PC_In: PC <= bus.
  - IncPC: PC <= PC + 1, modulo 2^32.
  - Both asserted: PC_In wins.
- MAR: MAR_In loads MAR <= bus.
- MDR: MDR_In loads MDR <= (Read ? mem[MAR[8:0]] : bus). Memory read is combinational from MAR.
- IR: IR_In loads IR <= bus.
- Register select/encode:
  - When G_RA = 1, decode Ra = IR[26:23] to a one-hot select.
  - When G_RA = 1 and R_In = 1, R[Ra] <= bus.
  - G_RA = 0 selects no register.
  - R0 is an ordinary writable register.
- HI: there is no external load path. HI holds HI_INIT.
- Memory:
  - Read-only from this block's ports.
  - Word 0 initialises to 32'hB880_0000 (mfhi R1). All other words initialise to 0.
  - Clear does not alter memory.
- IR opcode field [31:27] = 5'b10111 denotes mfhi. Decoding it is the sequencer's job; this block only exposes the Ra field.

## Timing
- Clear = 1, asynchronously and for as long as it is held:
  - PC, IR, MAR, MDR and R0–R15 go to 0.
  - HI goes to HI_INIT.
  - All load and increment enables are ignored.
- Reset outputs: BusMux_Out = 0 unless HI_Out (gives HI_INIT) or a cleared source is driven.
- Loads take effect at the rising edge where the enable is high. The new value appears on the bus in the same cycle after the edge.
- Same-edge transfer, e.g. PC_Out + MAR_In + IncPC: MAR captures the pre-increment PC and PC increments on that edge.
- Reference mfhi sequence, one step per cycle:
  - T0: PC_Out, MAR_In, IncPC.
  - T1: Read, MDR_In.
  - T2: MDR_Out, IR_In.
  - T3: HI_Out, G_RA, R_In.
  - Result: R[IR[26:23]] = HI after the T3 edge. Total latency is 4 cycles from T0.
- Clear asserted mid-sequence aborts it immediately. No partial load completes after Clear rises.

## Test plan
- Reset: assert Clear, pulse clocks with all enables high → PC/IR/MAR/MDR/R0–R15 = 0, HI = HI_INIT, bus = 0 with only PC_Out set.
- Fetch: release Clear, run T0–T2 → MAR = 0, PC = 1, MDR = IR = 32'hB880_0000.
- mfhi with HI_INIT = 32'h1234_5678: run T0–T3 → R1 = 32'h1234_5678, all other registers 0.
- Bus priority: assert PC_Out, MDR_Out and HI_Out together → bus = PC. Deassert PC_Out → bus = MDR. No enables → bus = 0.
- MDR from bus: Read = 0, MDR_In = 1, PC_Out = 1 with PC = 1 → MDR = 1.
- Mid-sequence reset: assert Clear during T3 → R1 remains 0, PC = 0.

Source files
------------

// File: rtl/datapath_if.sv
// Control-step and bus interface between the external sequencer and the datapath.
interface datapath_if;
   logic [4:0]  CONTROL;
   logic        IncPC;
   logic        Read;
   logic        PC_Out;
   logic        MDR_Out;
   logic        HI_Out;
   logic        PC_In;
   logic        MDR_In;
   logic        MAR_In;
   logic        IR_In;
   logic        G_RA;
   logic        R_In;
   logic [31:0] BusMux_Out;

   modport master (
      output CONTROL, IncPC, Read, PC_Out, MDR_Out, HI_Out,
             PC_In, MDR_In, MAR_In, IR_In, G_RA, R_In,
      input  BusMux_Out
   );

   modport slave (
      input  CONTROL, IncPC, Read, PC_Out, MDR_Out, HI_Out,
             PC_In, MDR_In, MAR_In, IR_In, G_RA, R_In,
      output BusMux_Out
   );
endinterface

// File: rtl/datapath.sv
// Single-bus 32-bit datapath: PC, IR, MAR, MDR, HI, R0-R15 and a boot ROM,
// all sourced from one prioritized bus mux; one register transfer per clock.
module datapath #(
   parameter int          MEM_DEPTH = 512,
   parameter logic [31:0] HI_INIT   = 32'h0000_0000
) (
   input  logic      Clock,
   input  logic      Clear,
   datapath_if.slave dp
);
   localparam logic [31:0] BOOT_WORD0 = 32'hB880_0000;

   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] mar_q, mar_d;
   logic [31:0] mdr_q, mdr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] r_q [16];
   logic [31:0] r_d [16];
   logic [31:0] bus_val;
   logic [31:0] mem_rdata;
   logic [8:0]  mem_addr;
   logic [15:0] ra_sel;

   always_comb begin
      bus_val = 32'h0;
      if (dp.PC_Out)       bus_val = pc_q;
      else if (dp.MDR_Out) bus_val = mdr_q;
      else if (dp.HI_Out)  bus_val = hi_q;
   end

   assign dp.BusMux_Out = bus_val;

   // Memory is a fixed boot image: only word 0 is non-zero, so no storage array is needed.
   assign mem_addr = mar_q[8:0];
   always_comb begin
      mem_rdata = 32'h0;
      if (mem_addr == 9'd0 && MEM_DEPTH > 0) mem_rdata = BOOT_WORD0;
   end

   always_comb begin
      ra_sel = '0;
      if (dp.G_RA) ra_sel[ir_q[26:23]] = 1'b1;
   end

   always_comb begin
      pc_d  = pc_q;
      ir_d  = ir_q;
      mar_d = mar_q;
      mdr_d = mdr_q;
      hi_d  = hi_q;
      if (dp.PC_In)      pc_d = bus_val;
      else if (dp.IncPC) pc_d = pc_q + 32'd1;
      if (dp.MAR_In) mar_d = bus_val;
      if (dp.IR_In)  ir_d  = bus_val;
      if (dp.MDR_In) mdr_d = dp.Read ? mem_rdata : bus_val;
      for (int i = 0; i < 16; i++) begin
         r_d[i] = r_q[i];
         if (ra_sel[i] && dp.R_In) r_d[i] = bus_val;
      end
   end

   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         pc_q  <= 32'h0;
         ir_q  <= 32'h0;
         mar_q <= 32'h0;
         mdr_q <= 32'h0;
         hi_q  <= HI_INIT;
         for (int i = 0; i < 16; i++) r_q[i] <= 32'h0;
      end else begin
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         mar_q <= mar_d;
         mdr_q <= mdr_d;
         hi_q  <= hi_d;
         for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
      end
   end

   // CONTROL is reserved for the ALU path; opcode and upper address bits are decoded elsewhere.
   logic unused_ok;
   assign unused_ok = ^{dp.CONTROL, ir_q[31:27], ir_q[22:0], mar_q[31:9]};
endmodule

// File: tb/tb_datapath.sv
// Directed plus randomized bench for datapath against a transfer-level reference model.
module tb_datapath;
   localparam logic [31:0] HI_V = 32'h1234_5678;

   // enable vector bit positions
   localparam logic [10:0] E_PCO = 11'd1 << 10;
   localparam logic [10:0] E_MDO = 11'd1 << 9;
   localparam logic [10:0] E_HIO = 11'd1 << 8;
   localparam logic [10:0] E_PCI = 11'd1 << 7;
   localparam logic [10:0] E_MDI = 11'd1 << 6;
   localparam logic [10:0] E_MAI = 11'd1 << 5;
   localparam logic [10:0] E_IRI = 11'd1 << 4;
   localparam logic [10:0] E_INC = 11'd1 << 3;
   localparam logic [10:0] E_RD  = 11'd1 << 2;
   localparam logic [10:0] E_GRA = 11'd1 << 1;
   localparam logic [10:0] E_RIN = 11'd1 << 0;
   localparam logic [10:0] T0 = E_PCO | E_MAI | E_INC;
   localparam logic [10:0] T1 = E_RD | E_MDI;
   localparam logic [10:0] T2 = E_MDO | E_IRI;
   localparam logic [10:0] T3 = E_HIO | E_GRA | E_RIN;

   logic Clock, Clear;
   datapath_if dp ();

   datapath #(.MEM_DEPTH(512), .HI_INIT(HI_V)) dut (
      .Clock(Clock),
      .Clear(Clear),
      .dp   (dp)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_pc, m_ir, m_mar, m_mdr;
   logic [31:0] m_r [16];
   logic [10:0] en;

   function automatic logic [31:0] mem_m(input logic [31:0] addr);
      return ((addr % 512) == 0) ? 32'hB880_0000 : 32'h0;
   endfunction

   function automatic logic [31:0] bus_m();
      if (en & E_PCO) return m_pc;
      if (en & E_MDO) return m_mdr;
      if (en & E_HIO) return HI_V;
      return 32'h0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0;
      foreach (m_r[i]) m_r[i] = 0;
   endtask

   task automatic drive(input logic [10:0] e, input logic clr);
      en = e;
      {dp.PC_Out, dp.MDR_Out, dp.HI_Out, dp.PC_In, dp.MDR_In, dp.MAR_In,
       dp.IR_In, dp.IncPC, dp.Read, dp.G_RA, dp.R_In} = e;
      dp.CONTROL = 5'($urandom);
      Clear = clr;
      if (clr) model_reset();
      #1;
      chk("bus", dp.BusMux_Out, bus_m());
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".pc"},  dut.pc_q,  m_pc);
      chk({tag, ".ir"},  dut.ir_q,  m_ir);
      chk({tag, ".mar"}, dut.mar_q, m_mar);
      chk({tag, ".mdr"}, dut.mdr_q, m_mdr);
      chk({tag, ".hi"},  dut.hi_q,  HI_V);
      for (int i = 0; i < 16; i++) chk($sformatf("%s.r%0d", tag, i), dut.r_q[i], m_r[i]);
   endtask

   // one clock: model applies the transfer unless Clear holds everything
   task automatic tick(input string tag);
      logic [31:0] b;
      logic [3:0]  ra;
      b  = bus_m();
      ra = m_ir[26:23];
      @(posedge Clock);
      if (!Clear) begin
         if (en & E_GRA && en & E_RIN) m_r[ra] = b;
         if (en & E_MDI) m_mdr = (en & E_RD) ? mem_m(m_mar) : b;
         if (en & E_MAI) m_mar = b;
         if (en & E_IRI) m_ir  = b;
         if (en & E_PCI)      m_pc = b;
         else if (en & E_INC) m_pc = m_pc + 1;
      end
      #1;
      check_state(tag);
   endtask

   initial begin
      en = '0;
      model_reset();
      // reset with all enables high
      drive(11'h7FF, 1'b1);
      tick("rst");
      tick("rst2");
      drive(E_PCO, 1'b1);
      chk("rst_bus_pco", dp.BusMux_Out, 32'h0);

      // fetch
      drive(T0, 1'b0); tick("t0");
      chk("fetch_mar", dut.mar_q, 32'h0);
      chk("fetch_pc", dut.pc_q, 32'h1);
      drive(T1, 1'b0); tick("t1");
      chk("fetch_mdr", dut.mdr_q, 32'hB880_0000);
      drive(T2, 1'b0); tick("t2");
      chk("fetch_ir", dut.ir_q, 32'hB880_0000);
      drive(T3, 1'b0); tick("t3");
      chk("mfhi_r1", dut.r_q[1], HI_V);
      chk("mfhi_r0", dut.r_q[0], 32'h0);

      // bus priority
      drive(E_PCO | E_MDO | E_HIO, 1'b0);
      chk("prio_pc", dp.BusMux_Out, 32'h1);
      drive(E_MDO | E_HIO, 1'b0);
      chk("prio_mdr", dp.BusMux_Out, 32'hB880_0000);
      drive(E_HIO, 1'b0);
      chk("prio_hi", dp.BusMux_Out, HI_V);
      drive(11'h0, 1'b0);
      chk("prio_none", dp.BusMux_Out, 32'h0);

      // MDR from bus
      drive(E_PCO | E_MDI, 1'b0); tick("mdr_bus");
      chk("mdr_from_bus", dut.mdr_q, 32'h1);

      // mid-sequence clear during T3
      drive(11'h0, 1'b1); tick("clr2");
      drive(T0, 1'b0); tick("b_t0");
      drive(T1, 1'b0); tick("b_t1");
      drive(T2, 1'b0); tick("b_t2");
      drive(T3, 1'b1);
      chk("abort_r1_async", dut.r_q[1], 32'h0);
      tick("abort");
      chk("abort_r1", dut.r_q[1], 32'h0);
      chk("abort_pc", dut.pc_q, 32'h0);

      // IncPC and PC_In together: PC_In wins
      drive(E_HIO | E_PCI | E_INC, 1'b0); tick("pc_in_wins");
      chk("pc_in_wins", dut.pc_q, HI_V);

      // randomized transfers with occasional clears
      for (int n = 0; n < 300; n++) begin
         drive(11'($urandom), ($urandom_range(0, 19) == 0));
         tick("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end
endmodule
